// File: rtl/ws2812_pkg.sv
// ws2812_pkg: shared types and constants for the WS2812 serialiser.
//   state_e      : transmitter FSM states
//   *_DEF        : default bit/reset timing in sys_clk cycles at 50 MHz
//   G/R/B_*      : field offsets inside a 24-bit GRB pixel word
//   cnt_w()      : counter width for a modulus, never below 1 bit
package ws2812_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    BIT  = 2'd2,
    RST  = 2'd3
  } state_e;

  localparam int T0H_DEF   = 20;     // 0.4 us high for a '0'
  localparam int T1H_DEF   = 40;     // 0.8 us high for a '1'
  localparam int T_BIT_DEF = 63;     // 1.26 us per bit
  localparam int T_RST_DEF = 15000;  // 300 us latch gap

  localparam int CYC_W = 16;         // cycle counter covers both bit and gap timing

  localparam int G_MSB = 23;
  localparam int G_LSB = 16;
  localparam int R_MSB = 15;
  localparam int R_LSB = 8;
  localparam int B_MSB = 7;
  localparam int B_LSB = 0;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ws2812_tx_if.sv
// ws2812_tx_if: handshake between the matrix config/draw stage and ws2812_tx.
//   ws2812_start : frame request (config -> tx)
//   cfg_data     : GRB colour of the current LED (config -> tx)
//   cfg_start    : advance-to-next-LED pulse (tx -> config)
//   busy         : transmitter not idle (tx -> config)
// master = config stage, slave = transmitter.
interface ws2812_tx_if;
  logic        ws2812_start;
  logic [23:0] cfg_data;
  logic        cfg_start;
  logic        busy;

  modport master (output ws2812_start, output cfg_data, input cfg_start, input busy);
  modport slave  (input ws2812_start, input cfg_data, output cfg_start, output busy);
endinterface

// File: rtl/ws2812_bit_enc.sv
// ws2812_bit_enc: per-bit line shaping.
//   bit_val : value of the bit being sent
//   cyc_cnt : cycle position inside the bit period
//   hi      : line should be high at this position
//   bit_end : last cycle of the bit period
module ws2812_bit_enc
  import ws2812_pkg::*;
#(
  parameter int T0H   = T0H_DEF,
  parameter int T1H   = T1H_DEF,
  parameter int T_BIT = T_BIT_DEF
) (
  input  logic             bit_val,
  input  logic [CYC_W-1:0] cyc_cnt,
  output logic             hi,
  output logic             bit_end
);
  assign hi      = cyc_cnt < (bit_val ? CYC_W'(T1H) : CYC_W'(T0H));
  assign bit_end = cyc_cnt == CYC_W'(T_BIT - 1);
endmodule

// File: rtl/ws2812_tx.sv
// ws2812_tx: serialises NUM_LED GRB pixels per frame onto the WS2812 line,
// then holds the line low for the latch gap.
//   sys_clk, sys_rst_n : clock, async active-low reset
//   cfg (slave)        : ws2812_start / cfg_data in, cfg_start / busy out
//   dout               : WS2812 data line (registered)
// Optional (WS2812_TX_STAT_EN):
//   frame_done : one-cycle pulse on the last gap cycle
//   frame_cnt  : wrapping count of frame_done pulses
module ws2812_tx
  import ws2812_pkg::*;
#(
  parameter int NUM_LED = 64,
  parameter int T0H     = T0H_DEF,
  parameter int T1H     = T1H_DEF,
  parameter int T_BIT   = T_BIT_DEF,
  parameter int T_RST   = T_RST_DEF
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  ws2812_tx_if.slave  cfg,
  output logic        dout
`ifdef WS2812_TX_STAT_EN
  ,
  output logic        frame_done,
  output logic [15:0] frame_cnt
`endif
);
  localparam int LED_W = cnt_w(NUM_LED);

  state_e           state, state_nxt;
  logic [CYC_W-1:0] cyc_cnt, cyc_nxt;
  logic [4:0]       bit_cnt, bit_nxt;
  logic [LED_W-1:0] led_cnt, led_nxt;
  logic [23:0]      sh, sh_nxt;
  logic             pending, pending_nxt;
  logic             cfg_start_q, cfg_start_nxt;
  logic             dout_nxt;
  logic             enc_hi, bit_end, rst_end;

  ws2812_bit_enc #(.T0H(T0H), .T1H(T1H), .T_BIT(T_BIT)) u_enc (
    .bit_val (sh[G_MSB]),
    .cyc_cnt (cyc_cnt),
    .hi      (enc_hi),
    .bit_end (bit_end)
  );

  assign rst_end   = (state == RST) && (cyc_cnt == CYC_W'(T_RST - 1));
  assign cfg.busy      = (state != IDLE);
  assign cfg.cfg_start = cfg_start_q;

  always_comb begin
    state_nxt     = state;
    cyc_nxt       = cyc_cnt;
    bit_nxt       = bit_cnt;
    led_nxt       = led_cnt;
    sh_nxt        = sh;
    pending_nxt   = pending;
    cfg_start_nxt = 1'b0;
    dout_nxt      = 1'b0;

    // a request while busy is remembered once; it is consumed at the end of the gap
    if (cfg.ws2812_start && state != IDLE) pending_nxt = 1'b1;

    case (state)
      IDLE: if (cfg.ws2812_start) state_nxt = LOAD;
      LOAD: begin
        sh_nxt    = cfg.cfg_data;
        bit_nxt   = '0;
        cyc_nxt   = '0;
        state_nxt = BIT;
      end
      BIT: begin
        dout_nxt = enc_hi;
        if (!bit_end) begin
          cyc_nxt = cyc_cnt + 1'b1;
        end else if (bit_cnt != 5'd23) begin
          sh_nxt  = {sh[22:0], 1'b0};
          bit_nxt = bit_cnt + 1'b1;
          cyc_nxt = '0;
        end else begin
          // registered below, so the pulse lands in the following LOAD/first RST cycle
          cfg_start_nxt = 1'b1;
          cyc_nxt       = '0;
          if (led_cnt == LED_W'(NUM_LED - 1)) begin
            led_nxt   = '0;
            state_nxt = RST;
          end else begin
            led_nxt   = led_cnt + 1'b1;
            state_nxt = LOAD;
          end
        end
      end
      RST: begin
        if (!rst_end) begin
          cyc_nxt = cyc_cnt + 1'b1;
        end else begin
          cyc_nxt     = '0;
          pending_nxt = 1'b0;
          state_nxt   = (pending || cfg.ws2812_start) ? LOAD : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= IDLE;
      cyc_cnt     <= '0;
      bit_cnt     <= '0;
      led_cnt     <= '0;
      sh          <= '0;
      pending     <= 1'b0;
      cfg_start_q <= 1'b0;
      dout        <= 1'b0;
    end else begin
      state       <= state_nxt;
      cyc_cnt     <= cyc_nxt;
      bit_cnt     <= bit_nxt;
      led_cnt     <= led_nxt;
      sh          <= sh_nxt;
      pending     <= pending_nxt;
      cfg_start_q <= cfg_start_nxt;
      dout        <= dout_nxt;
    end
  end

`ifdef WS2812_TX_STAT_EN
  logic [15:0] frame_cnt_q;

  assign frame_done = rst_end;
  assign frame_cnt  = frame_cnt_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)   frame_cnt_q <= '0;
    else if (rst_end) frame_cnt_q <= frame_cnt_q + 16'd1;
  end
`endif

endmodule

// File: tb/tb_ws2812_tx.sv
// tb_ws2812_tx: randomized bench for ws2812_tx with a timeline reference model.
// Inputs change 2 time units after posedge; outputs are sampled on negedge.
// Define WS2812_TX_STAT_EN to also exercise frame_done / frame_cnt.
module tb_ws2812_tx;
  localparam int NUM_LED   = 2;
  localparam int T0H       = ws2812_pkg::T0H_DEF;
  localparam int T1H       = ws2812_pkg::T1H_DEF;
  localparam int T_BIT     = ws2812_pkg::T_BIT_DEF;
  localparam int T_RST     = 100;
  localparam int LED_CYC   = 1 + 24*T_BIT;       // LOAD + 24 bit periods
  localparam int FRAME_CYC = NUM_LED*LED_CYC;
  localparam int BUDGET    = 20000;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b1;
  logic dout;
  ws2812_tx_if cfg();
`ifdef WS2812_TX_STAT_EN
  logic        frame_done;
  logic [15:0] frame_cnt;
`endif

  ws2812_tx #(
    .NUM_LED(NUM_LED), .T0H(T0H), .T1H(T1H), .T_BIT(T_BIT), .T_RST(T_RST)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .cfg       (cfg),
    .dout      (dout)
`ifdef WS2812_TX_STAT_EN
    ,
    .frame_done(frame_done),
    .frame_cnt (frame_cnt)
`endif
  );

  always #10 sys_clk = ~sys_clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- observed events (cycle stamps) ----------------
  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int act_rise[$], act_wid[$], act_cs[$], act_bf[$], act_br[$], act_fd[$];
  int exp_rise[$], exp_wid[$], exp_cs[$], exp_bf[$], exp_br[$], exp_fd[$];

  logic [23:0] pix [NUM_LED];
  int   ptr      = 0;
  bit   noise_en = 1'b0;
  bit   dout_p   = 1'b0;
  bit   busy_p   = 1'b0;
  logic start_d  = 1'b0;
  int   hi_len   = 0;

  always @(negedge sys_clk) begin
    if (dout === 1'b1) begin
      if (!dout_p) act_rise.push_back(cyc);
      hi_len++;
    end else if (dout_p) begin
      act_wid.push_back(hi_len);
      hi_len = 0;
    end
    dout_p = (dout === 1'b1);
    if (cfg.cfg_start === 1'b1) act_cs.push_back(cyc);
    if (cfg.busy === 1'b1 && !busy_p) act_br.push_back(cyc);
    if (cfg.busy !== 1'b1 && busy_p) act_bf.push_back(cyc);
    busy_p = (cfg.busy === 1'b1);
`ifdef WS2812_TX_STAT_EN
    if (frame_done === 1'b1) act_fd.push_back(cyc);
`endif
    // config stage: pointer advances on each cfg_start and wraps per frame;
    // optional noise on cfg_data outside the cycles where it must be valid
    if (cfg.cfg_start === 1'b1) ptr = (ptr + 1) % NUM_LED;
    if (noise_en && cfg.cfg_start !== 1'b1 && start_d !== 1'b1) cfg.cfg_data = 24'($urandom);
    else cfg.cfg_data = pix[ptr];
    start_d = cfg.ws2812_start;
  end

  // ---------------- reference model ----------------
  // Frame whose first LOAD is at cycle L: bit j of LED i starts at
  // L + i*LED_CYC + 1 + j*T_BIT and dout follows one cycle later.
  task automatic model_frame(input int L, output int nxt);
    for (int i = 0; i < NUM_LED; i++) begin
      for (int j = 0; j < 24; j++) begin
        int bs;
        bs = L + i*LED_CYC + 1 + j*T_BIT;
        exp_rise.push_back(bs + 1);
        exp_wid.push_back(pix[i][23-j] ? T1H : T0H);
      end
      exp_cs.push_back(L + (i+1)*LED_CYC);
    end
    exp_fd.push_back(L + FRAME_CYC + T_RST - 1);
    nxt = L + FRAME_CYC + T_RST;
  endtask

  task automatic clr();
    act_rise.delete(); act_wid.delete(); act_cs.delete();
    act_bf.delete();   act_br.delete();  act_fd.delete();
    exp_rise.delete(); exp_wid.delete(); exp_cs.delete();
    exp_bf.delete();   exp_br.delete();  exp_fd.delete();
    hi_len = 0;
  endtask

  task automatic cmp_q(input string tag, input int got[$], input int exp[$]);
    chk({tag, ".n"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      chk($sformatf("%s[%0d]", tag, i), got[i], exp[i]);
      if (got[i] != exp[i]) break;
    end
  endtask

  task automatic check_all(input string tag);
    cmp_q({tag, ".rise"},  act_rise, exp_rise);
    cmp_q({tag, ".width"}, act_wid,  exp_wid);
    cmp_q({tag, ".cfg_start"}, act_cs, exp_cs);
    cmp_q({tag, ".busy_up"},   act_br, exp_br);
    cmp_q({tag, ".busy_down"}, act_bf, exp_bf);
`ifdef WS2812_TX_STAT_EN
    cmp_q({tag, ".frame_done"}, act_fd, exp_fd);
`endif
  endtask

  task automatic step();
    @(posedge sys_clk);
    #2;
  endtask

  task automatic start_at(input int t);
    while (cyc < t) step();
    cfg.ws2812_start = 1'b1;
    step();
    cfg.ws2812_start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (cfg.busy === 1'b1 && n < BUDGET) begin
      step();
      n++;
    end
    chk({tag, ".idle_in_budget"}, (n < BUDGET), 1);
    repeat (4) step();
  endtask

  task automatic rand_pix();
    for (int i = 0; i < NUM_LED; i++) pix[i] = 24'($urandom);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, L, n1, n2, n3;
    cfg.ws2812_start = 1'b0;
    for (int i = 0; i < NUM_LED; i++) pix[i] = '0;

    // reset state
    #1 sys_rst_n = 1'b0;
    #2;
    chk("rst.dout", dout, 0);
    chk("rst.busy", cfg.busy, 0);
    chk("rst.cfg_start", cfg.cfg_start, 0);
    repeat (3) step();
    sys_rst_n = 1'b1;
    repeat (10) step();
    chk("rst.idle_busy", cfg.busy, 0);

    // 1: fixed pixels, single frame from idle
    clr();
    pix[0] = 24'hFF0000; pix[1] = 24'h00000F;
    k = cyc; start_at(k); L = k + 1;
    model_frame(L, n1); exp_br.push_back(L); exp_bf.push_back(n1);
    wait_idle("t1");
    check_all("t1");

    // 2: alternating pattern with cfg_data noise outside LOAD
    clr();
    pix[0] = 24'hA5A5A5; pix[1] = 24'hA5A5A5;
    noise_en = 1'b1;
    k = cyc; start_at(k); L = k + 1;
    model_frame(L, n1); exp_br.push_back(L); exp_bf.push_back(n1);
    wait_idle("t2");
    noise_en = 1'b0;
    check_all("t2");

    // 3: request during LED1 bits and again during the gap -> one chained frame
    clr(); rand_pix();
    k = cyc + int'($urandom_range(0, 7)); start_at(k); L = k + 1;
    model_frame(L, n1); model_frame(n1, n2);
    exp_br.push_back(L); exp_bf.push_back(n2);
    start_at(L + LED_CYC + 1 + int'($urandom_range(0, 24*T_BIT - 1)));
    start_at(L + FRAME_CYC + int'($urandom_range(0, T_RST - 2)));
    wait_idle("t3");
    check_all("t3");

    // 4: request on the last gap cycle -> straight to LOAD, nothing pending after
    clr(); rand_pix();
    k = cyc; start_at(k); L = k + 1;
    model_frame(L, n1); model_frame(n1, n2);
    exp_br.push_back(L); exp_bf.push_back(n2);
    start_at(L + FRAME_CYC + T_RST - 1);
    wait_idle("t4");
    check_all("t4");

    // 5: reset while LED0 bit 4 is high
    clr(); rand_pix();
    k = cyc; start_at(k); L = k + 1;
    while (cyc < L + 1 + 4*T_BIT + 7) step();
    chk("t5.dout_high_before", dout, 1);
    #3 sys_rst_n = 1'b0;
    #1;
    chk("t5.dout_in_rst", dout, 0);
    chk("t5.busy_in_rst", cfg.busy, 0);
    chk("t5.cfg_start_in_rst", cfg.cfg_start, 0);
    step(); step();
    clr();
    ptr = 0;
    sys_rst_n = 1'b1;
    repeat (20) step();
    chk("t5.no_cfg_start_after", act_cs.size(), 0);
    chk("t5.stays_idle", act_br.size(), 0);
    clr();
    k = cyc; start_at(k); L = k + 1;
    model_frame(L, n1); exp_br.push_back(L); exp_bf.push_back(n1);
    wait_idle("t5");
    check_all("t5");

`ifdef WS2812_TX_STAT_EN
    // 6: three chained frames, then frame counter wrap
    sys_rst_n = 1'b0;
    step(); step();
    sys_rst_n = 1'b1;
    chk("t6.frame_cnt_rst", frame_cnt, 0);
    clr(); rand_pix(); ptr = 0;
    step();
    k = cyc; start_at(k); L = k + 1;
    model_frame(L, n1); model_frame(n1, n2); model_frame(n2, n3);
    exp_br.push_back(L); exp_bf.push_back(n3);
    start_at(L + 100);
    start_at(n1 + 100);
    wait_idle("t6");
    check_all("t6");
    chk("t6.frame_cnt", frame_cnt, 3);
    force dut.frame_cnt_q = 16'hFFFF;
    step();
    release dut.frame_cnt_q;
    step();
    chk("t6.frame_cnt_forced", frame_cnt, 16'hFFFF);
    clr();
    k = cyc; start_at(k); L = k + 1;
    model_frame(L, n1); exp_br.push_back(L); exp_bf.push_back(n1);
    wait_idle("t6w");
    check_all("t6w");
    chk("t6.frame_cnt_wrap", frame_cnt, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
